// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder.
// State encoding and default operand width.
package serial_adder_pkg;

  localparam int DEF_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational full-adder cell shared by every bit
// of the serial addition.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ z;
  assign co = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder, LSB first, one bit per clock.
// Result is published to sum/cout only when the last bit completes.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_q;
  state_t        state_d;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  res_q;
  logic [N-1:0]  res_d;
  logic          carry_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  sum_q;
  logic          cout_q;
  logic          s;
  logic          co;
  logic          last;

  fa_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .z  (carry_q),
    .s  (s),
    .co (co)
  );

  assign last  = (cnt_q == LAST);
  assign res_d = {s, res_q[N-1:1]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = ADD;
      ADD:  if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        ADD: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_d;
          carry_q <= co;
          cnt_q   <= cnt_q + CW'(1);
          // publish only on the final bit so sum never shows a partial value
          if (last) begin
            sum_q  <= res_d;
            cout_q <= co;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (N=8 and N=2).
// Expected results come from plain integer addition.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;

  int total;
  int bad;

  logic [7:0] exp_sum;
  logic       exp_cout;

  serial_adder #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder #(.N(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // One N=8 addition; poke drives junk start/operands while busy/done.
  task automatic add8(input logic [7:0] x,
                      input logic [7:0] y,
                      input bit poke);
    int ref_v;
    ref_v = int'(x) + int'(y);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    chk("busy_e0", busy, 1);
    chk("done_e0", done, 0);
    start = poke;
    a = poke ? 8'h11 : 8'h00;
    b = poke ? 8'h22 : 8'h00;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("busy", busy, (k < 8) ? 1 : 0);
      chk("done", done, (k == 8) ? 1 : 0);
      if (k < 8) begin
        chk("sum_hold", sum, exp_sum);
        chk("cout_hold", cout, exp_cout);
      end
    end
    exp_sum  = ref_v[7:0];
    exp_cout = ref_v[8];
    chk("sum", sum, exp_sum);
    chk("cout", cout, exp_cout);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_sum", sum, exp_sum);
    start = 1'b0;
  endtask

  task automatic add2(input logic [1:0] x, input logic [1:0] y);
    int ref_v;
    ref_v = int'(x) + int'(y);
    a2 = x;
    b2 = y;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("n2_busy0", busy2, 1);
    @(negedge clk);
    chk("n2_done1", done2, 0);
    @(negedge clk);
    chk("n2_done2", done2, 1);
    chk("n2_busy2", busy2, 0);
    chk("n2_sum", sum2, ref_v[1:0]);
    chk("n2_cout", cout2, ref_v[2]);
    @(negedge clk);
    chk("n2_idle", done2, 0);
  endtask

  initial begin
    int pulses;
    int last_cyc;
    logic prev_done;
    total = 0;
    bad = 0;
    exp_sum = '0;
    exp_cout = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    start2 = 1'b0;
    a2 = '0;
    b2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum2", sum2, 0);
    rst_n = 1'b1;
    @(negedge clk);

    add8(8'h3C, 8'h5A, 1'b0);
    add8(8'hFF, 8'h01, 1'b0);
    add8(8'hFF, 8'hFF, 1'b0);
    add8(8'h3C, 8'h5A, 1'b1);
    chk("poke_sum", sum, 8'h96);

    // reset in the middle of an addition
    a = 8'h3C;
    b = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_sum = '0;
    exp_cout = 1'b0;
    @(negedge clk);
    chk("post_rst_sum", sum, 0);
    add8(8'h01, 8'h02, 1'b0);

    // start held high
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    pulses = 0;
    last_cyc = -1;
    prev_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        chk("cont_sum", sum, 8'h30);
        chk("cont_adj", prev_done, 0);
        if (last_cyc >= 0) chk("cont_gap", c - last_cyc, 10);
        last_cyc = c;
        pulses++;
      end
      prev_done = done;
    end
    start = 1'b0;
    chk("cont_pulses", pulses, 4);
    repeat (12) @(negedge clk);
    exp_sum = 8'h30;
    exp_cout = 1'b0;
    chk("cont_idle", busy, 0);

    for (int i = 0; i < 24; i++) begin
      add8(8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
    end

    add2(2'd3, 2'd1);
    for (int i = 0; i < 16; i++) begin
      add2(2'(i), 2'(i >> 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder that sums two operands one bit per clock, LSB first. Each bit passes through a single full-adder cell; its carry-out is registered and fed back as the next bit's carry-in. The block sits around that combinational full-adder cell. It supplies the cell's operand bits and carry-in from shift registers and a carry flip-flop, and collects the cell's sum bit into a result shift register. It is the area-minimal arithmetic stage for the datapath exercises.

## Interface
- N, default 8, operand and result width in bits; legal range N ≥ 2.
- Clock  in  1  rising-edge clock, the only clock.
- Resetn  in  1  asynchronous, active-low reset.
- start  in  1  request to begin an addition; sampled only in IDLE.
- a  in  N  operand A; captured on the edge that accepts start.
- b  in  N  operand B; captured on the edge that accepts start.
- busy  out  1  high while in state ADD.
- done  out  1  high for exactly one cycle when sum and cout become valid.
- sum  out  N  result, A+B mod 2^N; holds its value until the next accepted start.
- cout  out  1  carry out of bit N-1; holds with sum.

## Operation
- Reset is asynchronous, active-low:
  - state = IDLE.
  - sum = 0, cout = 0, done = 0, busy = 0.
  - Operand shift registers, carry flip-flop and bit counter all cleared.
- State IDLE:
  - When start = 1: load a and b into the operand shift registers, clear carry and counter, go to ADD.
  - When start = 0: stay in IDLE.
- State ADD, one bit per edge:
  - Cell inputs: x = A_reg[0], y = B_reg[0], z = carry.
  - s = x ^ y ^ z; co = majority(x, y, z).
  - Result shift register shifts right with s entering at bit N-1.
  - carry <= co; A_reg and B_reg shift right; counter increments.
  - When the counter reaches N-1 on this edge (the last bit), go to DONE.
- State DONE:
  - done = 1 and cout = carry; sum already holds the complete result.
  - Next edge goes to IDLE unconditionally.
- start is ignored outside IDLE, including in DONE. Changes to a and b after the load edge have no effect.
- sum and cout are updated only by a completed addition; an aborted operation leaves them at their reset value.
- Counter width is clog2(N). No other arithmetic is performed; overflow appears only as cout.

## Timing
- Let edge 0 be the rising edge that samples start = 1 in IDLE.
- Bit i is added on edge i+1. Edges 1 through N perform the N bit additions.
- After edge N: state is DONE, done = 1, busy = 0, sum and cout are valid.
- Edge N+1 returns the block to IDLE. The earliest next accepted start is on edge N+2, so throughput is one addition per N+2 cycles.
- busy is high from after edge 0 until after edge N, which is N cycles.
- done is a registered (Moore) output; it is never high in consecutive cycles.
- Resetn asserted at any point (mid-ADD or in DONE) immediately clears all outputs and state. No partial result is exposed.
- start held high continuously: a new addition is accepted on each IDLE edge, with a fresh operand capture each time.

## Structure
- Shared package holds:
  - The state encoding constants IDLE, ADD and DONE (2-bit).
  - The default width constant used for N.
- One natural sub-module, fa_cell: purely combinational, inputs x, y, z, outputs s, co. It is instantiated once.
- Top level holds the FSM, the two operand shift registers, the result shift register, the carry flip-flop and the counter.

## Test plan
- N=8, a=0x3C, b=0x5A, pulse start:
  - done = 1 exactly 8 cycles after the start edge.
  - sum = 0x96, cout = 0.
  - busy high for 8 cycles.
- a=0xFF, b=0x01: sum = 0x00, cout = 1. Then a=0xFF, b=0xFF: sum = 0xFE, cout = 1.
- start re-asserted with a=0x11, b=0x22 during ADD of 0x3C+0x5A: ignored, and the result remains 0x96, cout = 0.
- Resetn pulled low at bit 4 of 0x3C+0x5A:
  - sum = 0, cout = 0, done = 0, busy = 0 immediately.
  - After release, 0x01+0x02 gives sum = 0x03.
- start held high continuously with a=0x10, b=0x20:
  - done pulses every 10 cycles.
  - sum = 0x30 each time; done is never high in adjacent cycles.
- N=2 instance, a=3, b=1: done 2 cycles after start, sum = 0, cout = 1.
